// File: rtl/slc_add_scheduler.sv
// Two-requester add/subtract scheduler that time-shares one external 8-bit carry chain,
// processing each W-bit operation as NBYTES sequential byte passes, LSB first.
module slc_add_scheduler #(
    parameter int NBYTES = 4
) (
    input  logic                  QCK,
    input  logic                  QRT_N,
    input  logic                  REQ0_VALID,
    input  logic                  REQ1_VALID,
    output logic                  REQ0_READY,
    output logic                  REQ1_READY,
    input  logic [8*NBYTES-1:0]   REQ0_A,
    input  logic [8*NBYTES-1:0]   REQ0_B,
    input  logic [8*NBYTES-1:0]   REQ1_A,
    input  logic [8*NBYTES-1:0]   REQ1_B,
    input  logic                  REQ0_SUB,
    input  logic                  REQ1_SUB,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_ID,
    output logic [8*NBYTES-1:0]   RSP_SUM,
    output logic                  RSP_CO,
    output logic [7:0]            SLC_A,
    output logic [7:0]            SLC_B,
    output logic                  SLC_CI,
    output logic                  SLC_QEN,
    input  logic [7:0]            SLC_FZ,
    input  logic                  SLC_CO
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            armed;
    logic            rr_ptr;
    logic            grant_id;
    logic            accept;
    logic            in_compute;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            sub_q;
    logic            id_q;
    logic            carry_q;
    logic [KW-1:0]   k_q;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;

    always_ff @(posedge QCK or negedge QRT_N) begin
        if (!QRT_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // armed stays low through the release cycle so no grant can coincide with reset exit
    always_comb begin
        state_nxt  = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RSP_VALID  = 1'b0;
        accept     = 1'b0;
        grant_id   = 1'b0;
        in_compute = 1'b0;
        SLC_A      = 8'h00;
        SLC_B      = 8'h00;
        SLC_CI     = 1'b0;
        SLC_QEN    = 1'b0;
        case (state)
            IDLE: begin
                grant_id = (REQ0_VALID && REQ1_VALID) ? rr_ptr : REQ1_VALID;
                if (armed && (REQ0_VALID || REQ1_VALID)) begin
                    REQ0_READY = ~grant_id;
                    REQ1_READY = grant_id;
                    accept     = 1'b1;
                    state_nxt  = COMPUTE;
                end
            end
            COMPUTE: begin
                in_compute = 1'b1;
                SLC_A      = a_byte;
                SLC_B      = b_byte ^ {8{sub_q}};
                SLC_CI     = (k_q == '0) ? sub_q : carry_q;
                SLC_QEN    = 1'b1;
                if (k_q == K_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (k_q == KW'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge QCK or negedge QRT_N) begin
        if (!QRT_N) begin
            armed   <= 1'b0;
            rr_ptr  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= 1'b0;
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                a_q    <= grant_id ? REQ1_A : REQ0_A;
                b_q    <= grant_id ? REQ1_B : REQ0_B;
                sub_q  <= grant_id ? REQ1_SUB : REQ0_SUB;
                id_q   <= grant_id;
                rr_ptr <= ~grant_id;
                k_q    <= '0;
            end else if (in_compute) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (k_q == KW'(i)) begin
                        sum_q[8*i +: 8] <= SLC_FZ;
                    end
                end
                carry_q <= SLC_CO;
                if (k_q != K_LAST) begin
                    k_q <= k_q + KW'(1);
                end
            end
        end
    end

    assign RSP_ID  = id_q;
    assign RSP_SUM = sum_q;
    assign RSP_CO  = carry_q;

endmodule

// File: tb/tb_slc_add_scheduler.sv
// Directed bench for slc_add_scheduler: a behavioural carry-chain model feeds the DUT and a
// scoreboard queue holds the expected result of every accepted operation.
module tb_slc_add_scheduler;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1, rdy0, rdy1, s0, s1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_co;
    logic [W-1:0]  rsp_sum;
    logic [7:0]    slc_a, slc_b, slc_fz;
    logic          slc_ci, slc_qen, slc_co;

    logic          n1_v0, n1_v1, n1_rdy0, n1_rdy1, n1_s0, n1_s1;
    logic [7:0]    n1_a0, n1_b0, n1_a1, n1_b1;
    logic          n1_rsp_valid, n1_rsp_ready, n1_rsp_id, n1_rsp_co;
    logic [7:0]    n1_rsp_sum;
    logic [7:0]    n1_slc_a, n1_slc_b, n1_slc_fz;
    logic          n1_slc_ci, n1_slc_qen, n1_slc_co;

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        co;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   n;
    int   lat;
    logic seen;
    exp_t e;

    always #5 clk = ~clk;

    assign {slc_co, slc_fz}       = {1'b0, slc_a} + {1'b0, slc_b} + {8'd0, slc_ci};
    assign {n1_slc_co, n1_slc_fz} = {1'b0, n1_slc_a} + {1'b0, n1_slc_b} + {8'd0, n1_slc_ci};

    slc_add_scheduler #(.NBYTES(NB)) dut (
        .QCK(clk), .QRT_N(rst_n),
        .REQ0_VALID(v0), .REQ1_VALID(v1), .REQ0_READY(rdy0), .REQ1_READY(rdy1),
        .REQ0_A(a0), .REQ0_B(b0), .REQ1_A(a1), .REQ1_B(b1),
        .REQ0_SUB(s0), .REQ1_SUB(s1),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
        .RSP_SUM(rsp_sum), .RSP_CO(rsp_co),
        .SLC_A(slc_a), .SLC_B(slc_b), .SLC_CI(slc_ci), .SLC_QEN(slc_qen),
        .SLC_FZ(slc_fz), .SLC_CO(slc_co)
    );

    slc_add_scheduler #(.NBYTES(1)) dut1 (
        .QCK(clk), .QRT_N(rst_n),
        .REQ0_VALID(n1_v0), .REQ1_VALID(n1_v1), .REQ0_READY(n1_rdy0), .REQ1_READY(n1_rdy1),
        .REQ0_A(n1_a0), .REQ0_B(n1_b0), .REQ1_A(n1_a1), .REQ1_B(n1_b1),
        .REQ0_SUB(n1_s0), .REQ1_SUB(n1_s1),
        .RSP_VALID(n1_rsp_valid), .RSP_READY(n1_rsp_ready), .RSP_ID(n1_rsp_id),
        .RSP_SUM(n1_rsp_sum), .RSP_CO(n1_rsp_co),
        .SLC_A(n1_slc_a), .SLC_B(n1_slc_b), .SLC_CI(n1_slc_ci), .SLC_QEN(n1_slc_qen),
        .SLC_FZ(n1_slc_fz), .SLC_CO(n1_slc_co)
    );

    function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input int w);
        exp_t        r;
        logic [64:0] mask, bb, full;
        mask  = (65'd1 << w) - 65'd1;
        bb    = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        full  = {1'b0, a} + bb + {64'd0, sub};
        r.id  = id;
        r.a   = a;
        r.b   = b;
        r.sub = sub;
        r.sum = full[63:0] & mask[63:0];
        r.co  = full[w];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns just after the accepting rising edge.
    task automatic do_accept(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sub);
        int k;
        if (id) begin
            v1 = 1'b1; a1 = a; b1 = b; s1 = sub;
        end else begin
            v0 = 1'b1; a0 = a; b0 = b; s0 = sub;
        end
        #1;
        k = 0;
        while (!(id ? rdy1 : rdy0) && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("grant", {rdy1, rdy0}, id ? 2'b10 : 2'b01);
        q.push_back(model(id, 64'(a), 64'(b), sub, W));
        @(posedge clk);
    endtask

    // Entered at the first falling edge after accept; consumes the response.
    task automatic do_finish(input int hold);
        exp_t x;
        int   l;
        x = q[0];
        #1;
        l = 1;
        check("byte0", {slc_qen, slc_a, slc_b, slc_ci},
              {1'b1, x.a[7:0], x.b[7:0] ^ {8{x.sub}}, x.sub});
        while (!rsp_valid && l < 40) begin
            @(negedge clk);
            #1;
            l++;
        end
        check("latency", l, NB + 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold", {rsp_valid, rsp_id, rsp_co, rsp_sum, rdy0, rdy1, slc_qen},
                  {1'b1, x.id, x.co, x.sum[W-1:0], 3'b000});
        end
        rsp_ready = 1'b1;
        #1;
        x = q.pop_front();
        check("rsp", {rsp_valid, rsp_id, rsp_co, rsp_sum, rdy0, rdy1, slc_qen},
              {1'b1, x.id, x.co, x.sum[W-1:0], 3'b000});
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("drop", rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 0; v1 = 0; s0 = 0; s1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 0;
        n1_v0 = 0; n1_v1 = 0; n1_s0 = 0; n1_s1 = 0;
        n1_a0 = 0; n1_b0 = 0; n1_a1 = 0; n1_b1 = 0; n1_rsp_ready = 0;
        repeat (2) @(negedge clk);

        // reset holds everything low even with a request pending
        v0 = 1'b1; a0 = 32'h0000_00FF; b0 = 32'h0000_0001; s0 = 1'b0;
        #1;
        check("reset_outs", {rdy0, rdy1, rsp_valid, slc_qen, slc_a, slc_b, slc_ci, rsp_sum, rsp_co, rsp_id}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_rdy", rdy0, 1'b0);
        @(negedge clk);

        // carry ripple into byte 1, long response stall with requester 1 waiting
        do_accept(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h0000_0001; s1 = 1'b0;
        do_finish(10);
        check("idle_next_rdy1", {rdy1, rdy0}, 2'b10);

        do_accept(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(negedge clk);
        v1 = 1'b0;
        do_finish(0);

        do_accept(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        do_finish(2);

        // reset in the second compute pass abandons the operation
        @(negedge clk);
        do_accept(1'b0, 32'h1122_3344, 32'h0101_0101, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        #1;
        check("k0_byte", slc_a, 8'h44);
        @(negedge clk);
        #1;
        check("k1_byte", {slc_qen, slc_a, slc_b, slc_ci}, {1'b1, 8'h33, 8'h01, 1'b0});
        rst_n = 1'b0;
        #1;
        check("async_reset", {rdy0, rdy1, rsp_valid, slc_qen, slc_a, slc_b, slc_ci, rsp_sum, rsp_co, rsp_id}, '0);
        void'(q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_abort", seen, 1'b0);
        do_accept(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        do_finish(0);

        // both requesters held valid from reset: grants must alternate
        @(negedge clk);
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_accept(logic'(i % 2), $urandom, $urandom, logic'($urandom_range(0, 1)));
            @(negedge clk);
            if (i == 3) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            do_finish(0);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid || rdy0 || rdy1) seen = 1'b1;
        end
        check("no_extra", seen, 1'b0);
        check("sb_empty", q.size(), 0);

        // single-byte configuration
        @(negedge clk);
        n1_v0 = 1'b1; n1_a0 = 8'h80; n1_b0 = 8'h80; n1_s0 = 1'b0;
        #1;
        n = 0;
        while (!n1_rdy0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("n1_grant", {n1_rdy1, n1_rdy0}, 2'b01);
        q1.push_back(model(1'b0, 64'h80, 64'h80, 1'b0, 8));
        @(posedge clk);
        @(negedge clk);
        n1_v0 = 1'b0;
        #1;
        lat = 1;
        while (!n1_rsp_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("n1_latency", lat, 2);
        n1_rsp_ready = 1'b1;
        #1;
        e = q1.pop_front();
        check("n1_rsp", {n1_rsp_valid, n1_rsp_id, n1_rsp_co, n1_rsp_sum}, {1'b1, e.id, e.co, e.sum[7:0]});
        @(negedge clk);
        n1_rsp_ready = 1'b0;
        #1;
        check("n1_drop", n1_rsp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slc_add_scheduler.md
SLC_ADD_SCHEDULER -- requirements
Module: slc_add_scheduler

Interface
REQ-001 Parameter NBYTES, default 4, SHALL set the number of 8-bit passes per operation (legal 1..8); W = 8*NBYTES.
REQ-002 QCK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 QRT_N  input  1  reset, asynchronous and active-low.
REQ-004 REQ0_VALID, REQ1_VALID  input  1 each  requester has an operation pending.
REQ-005 REQ0_READY, REQ1_READY  output  1 each  operation accepted this cycle.
REQ-006 REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  W each  operands.
REQ-007 REQ0_SUB, REQ1_SUB  input  1 each  1 = A-B, 0 = A+B.
REQ-008 RSP_VALID  output  1; RSP_READY  input  1  result handshake.
REQ-009 RSP_ID  output  1  index of requester that owns the result.
REQ-010 RSP_SUM  output  W; RSP_CO  output  1  result and final carry-out.
REQ-011 SLC_A, SLC_B  output  8 each  operand byte driven to the shared super logic cell carry chain.
REQ-012 SLC_CI  output  1  carry-in to the chain; SLC_QEN  output  1  chain flop enable.
REQ-013 SLC_FZ  input  8; SLC_CO  input  1  combinational sum byte and carry-out returned by the chain.

Function
REQ-014 FSM SHALL have states IDLE, COMPUTE, RESP; reset state IDLE.
REQ-015 In IDLE, if any REQx_VALID is high, the block SHALL assert READY to exactly one requester, chosen by round-robin (priority to the requester not granted last); accept occurs when VALID and READY are both high.
REQ-016 READY SHALL be low in COMPUTE and RESP; READY SHALL never depend on RSP_READY.
REQ-017 On accept, the block SHALL latch A, B, SUB and ID, clear byte index k to 0, and go to COMPUTE next cycle.
REQ-018 In COMPUTE, SLC_A = A[8k+7:8k], SLC_B = B[8k+7:8k] XOR {8{SUB}}, SLC_CI = SUB when k=0, else the registered carry; SLC_QEN = 1.
REQ-019 Each COMPUTE cycle SHALL register SLC_FZ into sum byte k and SLC_CO into the carry register, then increment k.
REQ-020 After the pass with k = NBYTES-1, the FSM SHALL go to RESP; RSP_CO = last registered SLC_CO (for SUB: 1 = no borrow).
REQ-021 Latency: accept in cycle T; COMPUTE in T+1..T+NBYTES; RSP_VALID high from T+NBYTES+1.
REQ-022 In RESP, RSP_VALID, RSP_ID, RSP_SUM and RSP_CO SHALL hold stable until RSP_READY is sampled high; the FSM then goes to IDLE the next cycle and RSP_VALID drops.
REQ-023 Outside COMPUTE, SLC_A, SLC_B and SLC_CI SHALL be 0 and SLC_QEN SHALL be 0.
REQ-024 Simultaneous VALID on both requesters: exactly one SHALL be granted; the other keeps VALID and SHALL be granted on the next IDLE.
REQ-025 The round-robin pointer SHALL update only on accept.
REQ-026 Wrap-around: sums SHALL be modulo 2^W, with overflow visible only through RSP_CO.

Reset
REQ-027 Asserting QRT_N low SHALL immediately (asynchronously) force IDLE, all READY/RSP_VALID/SLC_QEN low, SLC_A/SLC_B/SLC_CI, RSP_SUM, RSP_CO, RSP_ID, k and carry to 0, and the round-robin pointer to favour requester 0.
REQ-028 Reset during COMPUTE or RESP SHALL abandon the operation with no response produced; the first operation after release SHALL be processed normally.
REQ-029 Deassertion SHALL take effect at the next QCK edge; no accept SHALL occur in the release cycle if QRT_N rises within that cycle.

Verification
REQ-030 NBYTES=4, REQ0 A=0x000000FF, B=0x00000001, SUB=0 -> RSP_SUM=0x00000100, RSP_CO=0, RSP_ID=0, RSP_VALID exactly 5 cycles after accept.
REQ-031 REQ1 A=0xFFFFFFFF, B=0x00000001, SUB=0 -> RSP_SUM=0x00000000, RSP_CO=1; A=5, B=7, SUB=1 -> RSP_SUM=0xFFFFFFFE, RSP_CO=0.
REQ-032 Both VALID held continuously from reset -> grants alternate 0,1,0,1; each request served exactly once.
REQ-033 RSP_READY held low 10 cycles -> RSP_* stable for all 10 cycles, both READY low; single-cycle RSP_READY -> IDLE next cycle.
REQ-034 QRT_N pulsed low in the 2nd COMPUTE cycle -> all outputs 0 immediately, no RSP_VALID; next request A=1, B=2 -> RSP_SUM=3.
REQ-035 NBYTES=1, A=0x80, B=0x80, SUB=0 -> RSP_SUM=0x00, RSP_CO=1, RSP_VALID 2 cycles after accept.
